// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave controller.
// Holds the FSM state enum, digit width, digit limits and a BCD helper.
package microwave_pkg;

   localparam int DIGIT_W    = 4;
   localparam int MAX_DIGITS = 3;
   localparam int BCD_MAX    = 9;
   localparam int CNT_W      = $clog2(MAX_DIGITS + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } mw_state_e;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/microwave_if.sv
// Keypad and countdown-timer bus of the microwave controller.
// master: controller side (keypad/timer_zero in, timer strobes out); slave: timer/keypad side.
interface microwave_if;
   import microwave_pkg::*;

   logic               keypad_valid;
   logic [DIGIT_W-1:0] keypad_digit;
   logic               timer_zero;
   logic               timer_load;
   logic [DIGIT_W-1:0] timer_digit;
   logic               timer_en;
   logic               timer_clr;

   modport master (
      input  keypad_valid, keypad_digit, timer_zero,
      output timer_load, timer_digit, timer_en, timer_clr
   );

   modport slave (
      output keypad_valid, keypad_digit, timer_zero,
      input  timer_load, timer_digit, timer_en, timer_clr
   );

endinterface

// File: rtl/microwave_controller_tick_gen.sv
// tick_gen: divide clk by TICK_DIV while en is high; registered one-cycle tick.
// Ports: clk, rst_n (async, active-low), restart (sync, count to 0), en, tick.
module tick_gen #(
   parameter int TICK_DIV = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic en,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else if (restart) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else if (en) begin
         tick  <= (cnt_q == LAST);
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end else begin
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/microwave_controller.sv
// Microwave oven controller: digit entry, cook/pause/done FSM, timer strobes.
// Ports: clk, clear (async active-low), bus (keypad/timer), start, stop,
// door_open, mag_on, beep, state. Optional beep: define MICROWAVE_BEEP_EN.
module microwave_controller
   import microwave_pkg::*;
#(
   parameter int TICK_DIV   = 100,
   parameter int BEEP_TICKS = 3
) (
   input  logic        clk,
   input  logic        clear,
   microwave_if.master bus,
   input  logic        start,
   input  logic        stop,
   input  logic        door_open,
   output logic        mag_on,
   output logic        beep,
   output logic [2:0]  state
);

   mw_state_e          state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n;
   logic               load_q, load_n;
   logic [DIGIT_W-1:0] digit_q, digit_n;
   logic               clr_q, clr_n;
   logic               mag_q;
   logic               digit_ok;
   logic               take;
   logic               done_end;
   logic               tick;

   assign digit_ok = bus.keypad_valid
                   && is_bcd(bus.keypad_digit)
                   && (cnt_q < CNT_W'(MAX_DIGITS));

   // Divider only runs while staying in COOK, so any exit
   // (including DONE) suppresses the pending timer_en.
   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst_n   (clear),
      .restart (state_n != COOK),
      .en      (state_q == COOK),
      .tick    (tick)
   );

`ifdef MICROWAVE_BEEP_EN
   localparam int BEEP_LEN = BEEP_TICKS * TICK_DIV;
   localparam int BW       = $clog2(BEEP_LEN + 1);

   logic [BW-1:0] bcnt_q;
   logic          beep_q;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         bcnt_q <= '0;
         beep_q <= 1'b0;
      end else begin
         bcnt_q <= (state_q == DONE) ? bcnt_q + 1'b1 : '0;
         beep_q <= (state_n == DONE);
      end
   end

   assign done_end = (bcnt_q == BW'(BEEP_LEN - 1));
   assign beep     = beep_q;
`else
   assign done_end = 1'b1;
   assign beep     = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      load_n  = 1'b0;
      digit_n = '0;
      clr_n   = 1'b0;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            take = digit_ok;
         end
         ENTRY: begin
            if (stop) begin
               clr_n   = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (start && !door_open && !bus.timer_zero) begin
               state_n = COOK;
            end else begin
               take = digit_ok;
            end
         end
         COOK: begin
            if (bus.timer_zero) begin
               state_n = DONE;
            end else if (door_open || stop) begin
               state_n = PAUSE;
            end
         end
         PAUSE: begin
            if (stop) begin
               clr_n   = 1'b1;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (start && !door_open) begin
               state_n = COOK;
            end
         end
         DONE: begin
            cnt_n = '0;
            if (done_end) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      if (take) begin
         load_n  = 1'b1;
         digit_n = bus.keypad_digit;
         cnt_n   = cnt_q + 1'b1;
         state_n = ENTRY;
      end
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         digit_q <= '0;
         clr_q   <= 1'b0;
         mag_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         load_q  <= load_n;
         digit_q <= digit_n;
         clr_q   <= clr_n;
         mag_q   <= (state_n == COOK);
      end
   end

   assign state           = state_q;
   assign mag_on          = mag_q;
   assign bus.timer_load  = load_q;
   assign bus.timer_digit = digit_q;
   assign bus.timer_clr   = clr_q;
   assign bus.timer_en    = tick;

endmodule

// File: tb/tb_microwave_controller.sv
// Self-checking bench for microwave_controller (TICK_DIV=4, BEEP_TICKS=3).
// Scoreboard queues hold expected load digits, timer_en and timer_clr cycles.
module tb_microwave_controller;

   localparam int TD = 4;
   localparam int BT = 3;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       door_open = 1'b0;
   logic       mag_on;
   logic       beep;
   logic [2:0] state;

   microwave_if bus();

   microwave_controller #(
      .TICK_DIV   (TD),
      .BEEP_TICKS (BT)
   ) dut (
      .clk       (clk),
      .clear     (clear),
      .bus       (bus),
      .start     (start),
      .stop      (stop),
      .door_open (door_open),
      .mag_on    (mag_on),
      .beep      (beep),
      .state     (state)
   );

   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int exp_load[$];
   int exp_en[$];
   int exp_clr[$];

   task automatic chk(input string tag, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every DUT strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.timer_load) begin
         chk("load_avail", int'(exp_load.size() > 0), 1);
         if (exp_load.size() > 0)
            chk("load_digit", int'(bus.timer_digit), exp_load.pop_front());
      end
      if (bus.timer_en) begin
         chk("en_avail", int'(exp_en.size() > 0), 1);
         if (exp_en.size() > 0)
            chk("en_cycle", cyc, exp_en.pop_front());
      end
      if (bus.timer_clr) begin
         chk("clr_avail", int'(exp_clr.size() > 0), 1);
         if (exp_clr.size() > 0)
            chk("clr_cycle", cyc, exp_clr.pop_front());
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic key(input int d, input bit ok);
      bus.keypad_valid = 1'b1;
      bus.keypad_digit = 4'(d);
      if (ok) exp_load.push_back(d);
      step();
      bus.keypad_valid = 1'b0;
      bus.keypad_digit = 4'd0;
   endtask

   // Start cooking; the k-th timer_en is due TD*(k+1) cycles after entry.
   task automatic cook_start(input int n_en);
      int c0;
      c0 = cyc;
      for (int i = 0; i < n_en; i++)
         exp_en.push_back(c0 + 1 + TD * (i + 1));
      start = 1'b1;
      step();
      start = 1'b0;
      chk("cook_state", int'(state), 2);
      chk("cook_mag", int'(mag_on), 1);
   endtask

   task automatic wait_en(input int want);
      int n;
      int bad;
      n   = 0;
      bad = 0;
      for (int i = 0; i < 10 * TD * want && n < want; i++) begin
         step();
         if (!mag_on) bad++;
         if (bus.timer_en) n++;
      end
      chk("en_count", n, want);
      chk("cook_mag_hold", bad, 0);
   endtask

   task automatic finish_done();
      int n;
      n = 0;
`ifdef MICROWAVE_BEEP_EN
      while (beep && n < 10 * TD * BT) begin
         n++;
         step();
      end
      chk("beep_len", n, TD * BT);
`else
      chk("beep_off", int'(beep), n);
      step();
`endif
      chk("idle_after_done", int'(state), 0);
   endtask

   initial begin
      bus.keypad_valid = 1'b0;
      bus.keypad_digit = 4'd0;
      bus.timer_zero   = 1'b0;

      #1 clear = 1'b0;
      #1;
      chk("rst_state", int'(state), 0);
      chk("rst_mag", int'(mag_on), 0);
      chk("rst_beep", int'(beep), 0);
      chk("rst_load", int'(bus.timer_load), 0);
      chk("rst_en", int'(bus.timer_en), 0);
      chk("rst_clr", int'(bus.timer_clr), 0);
      chk("rst_digit", int'(bus.timer_digit), 0);
      step();
      clear = 1'b1;
      step();

      // Full cook: 1,3,0 then start, five ticks, then timer reaches zero
      key(1, 1);
      chk("entry_state", int'(state), 1);
      key(3, 1);
      key(0, 1);
      cook_start(5);
      wait_en(5);
      bus.timer_zero = 1'b1;
      step();
      bus.timer_zero = 1'b0;
      chk("done_state", int'(state), 4);
      chk("done_mag", int'(mag_on), 0);
      finish_done();
      chk("en_pending_a", exp_en.size(), 0);

      // Door opens at divider=2, then resume
      key(2, 1);
      cook_start(0);
      step();
      step();
      door_open = 1'b1;
      step();
      chk("pause_state", int'(state), 3);
      chk("pause_mag", int'(mag_on), 0);
      start = 1'b1;
      step();
      chk("pause_door_hold", int'(state), 3);
      start = 1'b0;
      door_open = 1'b0;
      step();
      cook_start(1);
      wait_en(1);
      door_open = 1'b1;
      step();
      door_open = 1'b0;
      chk("pause_again", int'(state), 3);

      // Stop in PAUSE, then a fresh digit, then stop in ENTRY
      stop = 1'b1;
      start = 1'b1;
      exp_clr.push_back(cyc + 1);
      step();
      stop = 1'b0;
      start = 1'b0;
      chk("stop_idle", int'(state), 0);
      key(5, 1);
      chk("entry_after_stop", int'(state), 1);
      stop = 1'b1;
      exp_clr.push_back(cyc + 1);
      step();
      stop = 1'b0;
      chk("stop_entry_idle", int'(state), 0);
      step();
      chk("clr_pending", exp_clr.size(), 0);

      // Digit limits: 9,9,9 accepted, 7 and 12 rejected
      key(9, 1);
      key(9, 1);
      key(9, 1);
      key(7, 0);
      key(12, 0);
      step();
      chk("load_pending_d", exp_load.size(), 0);
      bus.timer_zero = 1'b1;
      start = 1'b1;
      step();
      chk("start_tz_hold", int'(state), 1);
      bus.timer_zero = 1'b0;
      door_open = 1'b1;
      step();
      chk("start_door_hold", int'(state), 1);
      start = 1'b0;
      door_open = 1'b0;

      // Simultaneous timer_zero/door/stop in COOK, keypad ignored
      cook_start(0);
      bus.timer_zero = 1'b1;
      door_open = 1'b1;
      stop = 1'b1;
      bus.keypad_valid = 1'b1;
      bus.keypad_digit = 4'd3;
      step();
      bus.timer_zero = 1'b0;
      door_open = 1'b0;
      stop = 1'b0;
      bus.keypad_valid = 1'b0;
      bus.keypad_digit = 4'd0;
      chk("prio_done", int'(state), 4);
      finish_done();

      // Asynchronous clear mid-COOK with a full digit count
      key(4, 1);
      key(4, 1);
      key(4, 1);
      cook_start(0);
      step();
      #2 clear = 1'b0;
      #1;
      chk("aclr_state", int'(state), 0);
      chk("aclr_mag", int'(mag_on), 0);
      chk("aclr_beep", int'(beep), 0);
      chk("aclr_en", int'(bus.timer_en), 0);
      chk("aclr_load", int'(bus.timer_load), 0);
      step();
      clear = 1'b1;
      step();
      chk("post_clr_idle", int'(state), 0);
      key(1, 1);
      key(2, 1);
      key(3, 1);
      step();
      chk("post_clr_entry", int'(state), 1);

      chk("load_pending", exp_load.size(), 0);
      chk("en_pending", exp_en.size(), 0);
      chk("clr_pending_end", exp_clr.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
